cache_replacement_ctrl: RTL and testbench

CACHE_REPLACEMENT_CTRL -- requirements
Module: cache_replacement_ctrl

---
 rtl/cache_replacement_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cache_replacement_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_replacement_ctrl.sv
// rtl/cache_replacement_ctrl.sv - victim selection and miss-handling controller for a set-associative cache
module cache_replacement_ctrl #(
    parameter int NUM_WAYS      = 4,
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              lookup_valid,
    output logic                              lookup_ready,
    input  logic                              lookup_hit,
    input  logic [NUM_WAYS-1:0]               hit_way,
    input  logic [NUM_WAYS-1:0]               way_valid,
    input  logic [NUM_WAYS-1:0]               way_dirty,
    input  logic [NUM_WAYS-1:0]               way_expired,
    input  logic [NUM_WAYS*COUNTER_WIDTH-1:0] way_age,
    output logic                              accessed,
    output logic [COUNTER_WIDTH-1:0]          accessed_way_age,
    output logic [NUM_WAYS-1:0]               allocate,
    output logic [NUM_WAYS-1:0]               victim_way,
    output logic                              wb_req,
    input  logic                              wb_ack,
    output logic                              fill_req,
    input  logic                              fill_done,
    output logic                              miss_done,
    output logic                              proto_err
);

    localparam int IDX_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WRITEBACK,
        S_FILL,
        S_UPDATE
    } state_t;

    state_t state, state_next;

    logic                     accept;
    logic                     hit_onehot;
    logic [COUNTER_WIDTH-1:0] hit_age;
    logic                     inv_found, exp_found;
    logic [IDX_W-1:0]         inv_idx, exp_idx, max_idx, sel_idx;
    logic [COUNTER_WIDTH-1:0] max_age, sel_age, victim_age;
    logic                     sel_dirty, sel_valid;
    logic [NUM_WAYS-1:0]      sel_onehot;

    assign lookup_ready = (state == S_IDLE);
    assign accept       = lookup_valid && lookup_ready;

    always_comb begin
        int ones;
        ones    = 0;
        hit_age = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (hit_way[i]) begin
                ones    = ones + 1;
                hit_age = way_age[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            end
        end
        hit_onehot = (ones == 1);
    end

    // Priority: first invalid way, then first expired way, then oldest (strict > keeps lowest index on ties).
    always_comb begin
        inv_found  = 1'b0;
        exp_found  = 1'b0;
        inv_idx    = '0;
        exp_idx    = '0;
        max_idx    = '0;
        max_age    = way_age[0 +: COUNTER_WIDTH];
        sel_age    = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!inv_found && !way_valid[i]) begin
                inv_found = 1'b1;
                inv_idx   = IDX_W'(i);
            end
            if (!exp_found && way_expired[i]) begin
                exp_found = 1'b1;
                exp_idx   = IDX_W'(i);
            end
            if (way_age[i*COUNTER_WIDTH +: COUNTER_WIDTH] > max_age) begin
                max_age = way_age[i*COUNTER_WIDTH +: COUNTER_WIDTH];
                max_idx = IDX_W'(i);
            end
        end
        sel_idx = inv_found ? inv_idx : (exp_found ? exp_idx : max_idx);
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_age = way_age[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            end
        end
        sel_dirty  = way_dirty[sel_idx];
        sel_valid  = way_valid[sel_idx];
        sel_onehot = NUM_WAYS'(1) << sel_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (accept && !lookup_hit) state_next = S_SELECT;
            S_SELECT:    state_next = (sel_valid && sel_dirty) ? S_WRITEBACK : S_FILL;
            S_WRITEBACK: if (wb_ack) state_next = S_FILL;
            S_FILL:      if (fill_done) state_next = S_UPDATE;
            S_UPDATE:    state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Pulse outputs default low every cycle; level outputs are set and cleared on state transitions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accessed         <= 1'b0;
            accessed_way_age <= '0;
            allocate         <= '0;
            victim_way       <= '0;
            victim_age       <= '0;
            wb_req           <= 1'b0;
            fill_req         <= 1'b0;
            miss_done        <= 1'b0;
            proto_err        <= 1'b0;
        end else begin
            accessed         <= 1'b0;
            accessed_way_age <= '0;
            allocate         <= '0;
            miss_done        <= 1'b0;
            proto_err        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && lookup_hit) begin
                        if (hit_onehot) begin
                            accessed         <= 1'b1;
                            accessed_way_age <= hit_age;
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                S_SELECT: begin
                    victim_way <= sel_onehot;
                    victim_age <= sel_age;
                    if (sel_valid && sel_dirty) begin
                        wb_req <= 1'b1;
                    end else begin
                        fill_req <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (wb_ack) begin
                        wb_req   <= 1'b0;
                        fill_req <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (fill_done) begin
                        fill_req         <= 1'b0;
                        allocate         <= victim_way;
                        accessed         <= 1'b1;
                        accessed_way_age <= victim_age;
                        miss_done        <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    victim_way <= '0;
                    victim_age <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_replacement_ctrl.sv
// tb/tb_cache_replacement_ctrl.sv - directed self-checking bench for cache_replacement_ctrl
module tb_cache_replacement_ctrl;
    localparam int NW = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic lookup_valid, lookup_ready, lookup_hit;
    logic [NW-1:0] hit_way, way_valid, way_dirty, way_expired;
    logic [NW*CW-1:0] way_age;
    logic accessed;
    logic [CW-1:0] accessed_way_age;
    logic [NW-1:0] allocate, victim_way;
    logic wb_req, wb_ack, fill_req, fill_done, miss_done, proto_err;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    cache_replacement_ctrl #(.NUM_WAYS(NW), .COUNTER_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
        .lookup_hit(lookup_hit), .hit_way(hit_way),
        .way_valid(way_valid), .way_dirty(way_dirty), .way_expired(way_expired),
        .way_age(way_age),
        .accessed(accessed), .accessed_way_age(accessed_way_age),
        .allocate(allocate), .victim_way(victim_way),
        .wb_req(wb_req), .wb_ack(wb_ack),
        .fill_req(fill_req), .fill_done(fill_done),
        .miss_done(miss_done), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: protocol phase plus the outputs the next cycle must show.
    typedef enum {P_IDLE, P_SEL, P_WB, P_FILL, P_UPD} phase_t;
    phase_t ph = P_IDLE;
    logic e_acc = 0, e_wb = 0, e_fill = 0, e_md = 0, e_pe = 0;
    logic [CW-1:0] e_age = 0;
    logic [NW-1:0] e_alloc = 0, e_vic = 0;
    int m_vage = 0;

    function automatic int age_of(input logic [NW*CW-1:0] a, input int w);
        logic [NW*CW-1:0] s;
        s = a >> (w * CW);
        return int'(s[CW-1:0]);
    endfunction

    function automatic int pick_victim(input logic [NW-1:0] v, input logic [NW-1:0] e,
                                       input logic [NW*CW-1:0] a);
        int best;
        for (int i = 0; i < NW; i++) if (!v[i]) return i;
        for (int i = 0; i < NW; i++) if (e[i]) return i;
        best = 0;
        for (int i = 1; i < NW; i++) if (age_of(a, i) > age_of(a, best)) best = i;
        return best;
    endfunction

    always @(posedge clk) begin
        int v;
        if (!rst_n) begin
            ph = P_IDLE;
            e_acc = 0; e_age = 0; e_alloc = 0; e_vic = 0;
            e_wb = 0; e_fill = 0; e_md = 0; e_pe = 0; m_vage = 0;
        end else begin
            e_acc = 0; e_age = 0; e_alloc = 0; e_md = 0; e_pe = 0;
            case (ph)
                P_IDLE: if (lookup_valid) begin
                    if (lookup_hit) begin
                        if ($countones(hit_way) == 1) begin
                            e_acc = 1;
                            for (int i = 0; i < NW; i++) if (hit_way[i]) e_age = CW'(age_of(way_age, i));
                        end else begin
                            e_pe = 1;
                        end
                    end else begin
                        ph = P_SEL;
                    end
                end
                P_SEL: begin
                    v = pick_victim(way_valid, way_expired, way_age);
                    e_vic = NW'(1 << v);
                    m_vage = age_of(way_age, v);
                    if (way_valid[v] && way_dirty[v]) begin e_wb = 1; ph = P_WB; end
                    else begin e_fill = 1; ph = P_FILL; end
                end
                P_WB: if (wb_ack) begin e_wb = 0; e_fill = 1; ph = P_FILL; end
                P_FILL: if (fill_done) begin
                    e_fill = 0; e_alloc = e_vic; e_acc = 1; e_age = CW'(m_vage); e_md = 1; ph = P_UPD;
                end
                P_UPD: begin e_vic = 0; ph = P_IDLE; end
                default: ph = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ready", lookup_ready, ph == P_IDLE);
            chk("m_accessed", accessed, e_acc);
            chk("m_age", accessed_way_age, e_age);
            chk("m_allocate", allocate, e_alloc);
            chk("m_victim", victim_way, e_vic);
            chk("m_wb_req", wb_req, e_wb);
            chk("m_fill_req", fill_req, e_fill);
            chk("m_miss_done", miss_done, e_md);
            chk("m_proto_err", proto_err, e_pe);
        end
    end

    task automatic hit(input logic [NW-1:0] w);
        @(negedge clk);
        lookup_valid = 1; lookup_hit = 1; hit_way = w;
        @(negedge clk);
        lookup_valid = 0; lookup_hit = 0; hit_way = 0;
    endtask

    task automatic start_miss();
        @(negedge clk);
        lookup_valid = 1; lookup_hit = 0;
        @(negedge clk);
        lookup_valid = 0;
    endtask

    // Responder: ack write-back after wb_delay held cycles, finish fill after n_fill fill_req cycles.
    task automatic service(input int n_fill, input int wb_delay, output logic [NW-1:0] vic,
                           output int lat, output int fills, output bit saw_wb);
        int wbc;
        lat = -1; vic = 0; fills = 0; saw_wb = 0; wbc = 0;
        for (int c = 1; c < 60; c++) begin
            if (miss_done) begin lat = c; break; end
            if (victim_way != 0 && vic == 0) vic = victim_way;
            if (wb_req) saw_wb = 1;
            wb_ack = wb_req && (wbc == wb_delay);
            if (wb_req) wbc++;
            fill_done = fill_req && (fills == n_fill - 1);
            if (fill_req) fills++;
            @(negedge clk);
        end
        wb_ack = 0; fill_done = 0;
        if (lat < 0) chk("miss_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NW-1:0] vic;
        int lat, fills;
        bit saw_wb;
        bit got;

        rst_n = 0; lookup_valid = 0; lookup_hit = 0; hit_way = 0;
        way_valid = 4'hF; way_dirty = 0; way_expired = 0; way_age = 0;
        wb_ack = 0; fill_done = 0;
        @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        chk("rst_accessed", accessed, 0);
        chk("rst_victim", victim_way, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_ready", lookup_ready, 1);

        way_age = {8'd9, 8'd5, 8'd2, 8'd1};
        hit(4'b0100);
        chk("hit_acc", accessed, 1);
        chk("hit_age", accessed_way_age, 5);
        chk("hit_alloc", allocate, 0);
        @(negedge clk);
        chk("hit_acc_drop", accessed, 0);

        @(negedge clk);
        lookup_valid = 1; lookup_hit = 1; hit_way = 4'b0001;
        @(negedge clk);
        chk("b2b_first_age", accessed_way_age, 1);
        hit_way = 4'b1000;
        @(negedge clk);
        lookup_valid = 0; lookup_hit = 0; hit_way = 0;
        chk("b2b_second_age", accessed_way_age, 9);

        hit(4'b0110);
        chk("perr_pulse", proto_err, 1);
        chk("perr_acc", accessed, 0);
        hit(4'b0000);
        chk("perr_zero", proto_err, 1);

        @(negedge clk);
        wb_ack = 1; fill_done = 1;
        @(negedge clk);
        wb_ack = 0; fill_done = 0;
        chk("stray_ready", lookup_ready, 1);
        chk("stray_fill", fill_req, 0);

        way_valid = 4'b1011; way_dirty = 4'b0100; way_expired = 0;
        start_miss();
        service(2, 0, vic, lat, fills, saw_wb);
        chk("inv_victim", vic, 4'b0100);
        chk("inv_alloc", allocate, 4'b0100);
        chk("inv_no_wb", saw_wb, 0);
        chk("inv_fills", fills, 2);
        chk("inv_latency_3pN", lat + 1, 5);
        @(negedge clk);
        chk("inv_victim_clr", victim_way, 0);
        chk("inv_ready_back", lookup_ready, 1);

        way_valid = 4'hF; way_dirty = 4'b1000; way_expired = 4'b1000;
        start_miss();
        service(1, 2, vic, lat, fills, saw_wb);
        chk("exp_victim", vic, 4'b1000);
        chk("exp_wb", saw_wb, 1);
        chk("exp_alloc", allocate, 4'b1000);
        chk("exp_fills", fills, 1);

        way_dirty = 0; way_expired = 0;
        way_age = {8'd1, 8'd7, 8'd7, 8'd3};
        start_miss();
        service(3, 0, vic, lat, fills, saw_wb);
        chk("age_victim", vic, 4'b0010);
        chk("age_value", accessed_way_age, 7);
        chk("age_latency_3pN", lat + 1, 6);

        @(negedge clk);
        lookup_valid = 1; lookup_hit = 1; hit_way = 4'b0100;
        @(negedge clk);
        lookup_hit = 0; hit_way = 0;
        chk("hm_hit_pulse", accessed, 1);
        @(negedge clk);
        lookup_valid = 0;
        chk("hm_busy", lookup_ready, 0);
        service(1, 0, vic, lat, fills, saw_wb);
        chk("hm_done", miss_done, 1);

        way_valid = 4'b1110;
        start_miss();
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (fill_req) begin got = 1; break; end
            @(negedge clk);
        end
        chk("rf_fill_seen", got, 1);
        rst_n = 0;
        @(negedge clk);
        chk("rf_fill_off", fill_req, 0);
        chk("rf_victim_off", victim_way, 0);
        chk("rf_md_off", miss_done, 0);
        rst_n = 1;
        fill_done = 1;
        @(negedge clk);
        fill_done = 0;
        chk("rf_ready", lookup_ready, 1);
        repeat (3) @(negedge clk);
        chk("rf_no_md", miss_done, 0);

        repeat (2) @(negedge clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
